// File: rtl/inst_fetch_sequencer.sv
// Fetches one instruction per issue: fetch, wait MEM_LATENCY cycles, decode, pulse start, then hold inst until done.
// Run-to-start latency is MEM_LATENCY+3 cycles; the next fetch begins only after done, and done is ignored outside WAIT_DONE.
module inst_fetch_sequencer #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned INST_W       = 16,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned DONE_TIMEOUT = 15,
  parameter logic [3:0]  HALT_OPCODE  = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd_en,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] inst,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic              halted,
  output logic              fault,
  output logic [15:0]       inst_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_LATCH     = 3'd2;
  localparam logic [2:0] S_DECODE    = 3'd3;
  localparam logic [2:0] S_ISSUE     = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;
  localparam logic [2:0] S_HALTED    = 3'd6;
  localparam logic [2:0] S_FAULT     = 3'd7;

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LATENCY);
  localparam logic [7:0] TO_LIMIT = 8'(DONE_TIMEOUT);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [INST_W-1:0] inst_q;
  logic [2:0]        lat_cnt;
  logic [7:0]        to_cnt;
  logic [7:0]        to_cnt_nxt;
  logic              step_pending;
  logic              halted_q;
  logic              fault_q;
  logic [15:0]       count_q;

  assign busy       = (state != S_IDLE) && (state != S_HALTED) && (state != S_FAULT);
  assign imem_rd_en = (state == S_FETCH);
  // Address follows pc_in during the strobe cycle so the memory sees it together with imem_rd_en.
  assign imem_addr  = (state == S_FETCH) ? pc_in : addr_q;
  assign start      = (state == S_ISSUE);
  assign inst       = inst_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign inst_count = count_q;
  assign to_cnt_nxt = to_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      inst_q       <= '0;
      lat_cnt      <= 3'd0;
      to_cnt       <= 8'd0;
      step_pending <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
      count_q      <= 16'd0;
    end else begin
      if (step && busy) begin
        step_pending <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (run || step || step_pending) begin
            state        <= S_FETCH;
            step_pending <= 1'b0;
          end
        end
        S_FETCH: begin
          addr_q  <= pc_in;
          lat_cnt <= LAT_LOAD;
          state   <= S_LATCH;
        end
        S_LATCH: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            inst_q <= imem_data;
            state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (inst_q[INST_W-1 -: 4] == HALT_OPCODE) begin
            state    <= S_HALTED;
            halted_q <= 1'b1;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          to_cnt <= 8'd0;
          state  <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // A done arriving in the last allowed cycle still retires the instruction.
          if (done) begin
            if (count_q != 16'hFFFF) begin
              count_q <= count_q + 16'd1;
            end
            state <= run ? S_FETCH : S_IDLE;
          end else begin
            to_cnt <= to_cnt_nxt;
            if (to_cnt_nxt == TO_LIMIT) begin
              state   <= S_FAULT;
              fault_q <= 1'b1;
            end
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule
